// File: rtl/prog_loader.sv
// Program-memory loader: packs a checksummed byte stream into 32-bit words,
// writes them from BASE_ADDR upward and holds the CPU in reset until the image is good.
module prog_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        start_ok;
   logic        word_full;
   logic        last_word;
   logic        n_too_big;
   logic [7:0]  n_hi;
   logic [7:0]  checksum;
   logic [15:0] n_hdr;
   logic [15:0] n_words;
   logic [1:0]  byte_idx;

   assign byte_ready = (state == S_HDR0) || (state == S_HDR1) ||
                       (state == S_DATA) || (state == S_CHK);
   assign accept     = byte_valid && byte_ready;
   assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign word_full  = (state == S_DATA) && accept && (byte_idx == 2'd3);
   assign n_hdr      = {n_hi, byte_data};
   assign n_too_big  = {1'b0, n_hdr} > 17'(DEPTH);
   // word_count has already caught up with every earlier word by the time a new word fills
   assign last_word  = (word_count + 16'd1) == n_words;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      error     = 1'b0;
      cpu_hold  = 1'b1;
      case (state)
         S_IDLE: if (start) state_nxt = S_HDR0;
         S_HDR0: if (accept) state_nxt = S_HDR1;
         S_HDR1: begin
            if (accept) begin
               if (n_hdr == 16'd0)  state_nxt = S_CHK;
               else if (n_too_big)  state_nxt = S_ERR;
               else                 state_nxt = S_DATA;
            end
         end
         // CHK is entered while the final word's write strobe is still up
         S_DATA: if (word_full && last_word) state_nxt = S_CHK;
         S_CHK: begin
            if (accept) state_nxt = (byte_data == checksum) ? S_DONE : S_ERR;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nxt = S_HDR0;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) state_nxt = S_HDR0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= ADDR_W'(BASE_ADDR);
         mem_wdata  <= '0;
         word_count <= '0;
         checksum   <= '0;
         n_hi       <= '0;
         n_words    <= '0;
         byte_idx   <= '0;
      end else begin
         mem_we <= word_full;
         if (start_ok) begin
            mem_addr   <= ADDR_W'(BASE_ADDR);
            word_count <= '0;
            checksum   <= '0;
            byte_idx   <= '0;
         end else begin
            if (mem_we) begin
               mem_addr   <= mem_addr + ADDR_W'(1);
               word_count <= word_count + 16'd1;
            end
            if (accept) begin
               case (state)
                  S_HDR0: n_hi    <= byte_data;
                  S_HDR1: n_words <= n_hdr;
                  S_DATA: begin
                     mem_wdata <= {mem_wdata[23:0], byte_data};
                     checksum  <= checksum ^ byte_data;
                     byte_idx  <= byte_idx + 2'd1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a word-list model predicts writes and load status;
// a negedge monitor pops expected writes whenever mem_we is seen.
module tb_prog_loader;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned BASE_ADDR = 0;
   localparam int unsigned DEPTH     = 1024;

   logic              clk;
   logic              rst;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [15:0]       word_count;

   prog_loader #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE_ADDR),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error),
      .word_count(word_count)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] words[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write
   always @(negedge clk) begin
      wr_t e;
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e.addr));
            check("wr_data", 64'(mem_wdata), 64'(e.data));
         end
      end
      if (rst === 1'b1 && (done || error)) check("done_error_exclusive", 64'(done && error), 64'd0);
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
      bit got;
      int unsigned g;
      g = gaps ? $urandom_range(0, 2) : 0;
      if (g > 0) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         repeat (g) begin @(posedge clk); #1; end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      start      = with_start;
      got        = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = byte_ready;
         @(posedge clk); #1;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   // Stream the image held in words[] with header n; the model predicts the rest.
   task automatic run_load(input logic [15:0] n, input bit use_ovr, input logic [7:0] ovr,
                           input bit gaps, input bit poke);
      logic [7:0]  good_chk, sent_chk, b;
      logic [31:0] w;
      bit          too_big, exp_done;
      int unsigned bi;
      too_big  = int'(n) > int'(DEPTH);
      good_chk = 8'h00;
      foreach (words[i]) begin
         w = words[i];
         for (int k = 3; k >= 0; k--) good_chk = good_chk ^ w[8*k +: 8];
      end
      sent_chk = use_ovr ? ovr : good_chk;
      exp_done = !too_big && (sent_chk == good_chk);
      if (!too_big)
         foreach (words[i]) exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + i), data: words[i]});
      pulse_start();
      send_byte(n[15:8], gaps, 1'b0);
      send_byte(n[7:0], gaps, 1'b0);
      if (!too_big) begin
         bi = 0;
         foreach (words[i]) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
               b = w[8*k +: 8];
               send_byte(b, gaps, poke && (bi == 5));
               bi++;
            end
         end
         send_byte(sent_chk, gaps, 1'b0);
      end
      @(negedge clk);
      check("done",       64'(done),       64'(exp_done));
      check("error",      64'(error),      64'(!exp_done));
      check("cpu_hold",   64'(cpu_hold),   64'(!exp_done));
      check("byte_ready", 64'(byte_ready), 64'd0);
      check("word_count", 64'(word_count), too_big ? 64'd0 : 64'(n));
      check("writes_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic set_spec_words();
      words.delete();
      words.push_back(32'h12345678);
      words.push_back(32'h9ABCDEF0);
   endtask

   task automatic set_rand_words(input int unsigned n);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      check({tag, "_mem_we"},     64'(mem_we),     64'd0);
      check({tag, "_mem_addr"},   64'(mem_addr),   64'(BASE_ADDR));
      check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
      check({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
      check({tag, "_done"},       64'(done),       64'd0);
      check({tag, "_error"},      64'(error),      64'd0);
      check({tag, "_word_count"}, 64'(word_count), 64'd0);
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // Two-word image with correct checksum, then wrong checksum bytes
      set_spec_words();
      run_load(16'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      run_load(16'd2, 1'b1, 8'h09, 1'b0, 1'b0);
      run_load(16'd2, 1'b1, 8'h08, 1'b0, 1'b1);

      // Empty image, and oversized header
      words.delete();
      run_load(16'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      run_load(16'(DEPTH + 1), 1'b0, 8'h00, 1'b0, 1'b0);

      // Same 3-word image streamed back-to-back and with random valid gaps
      set_rand_words(3);
      run_load(16'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      run_load(16'd3, 1'b0, 8'h00, 1'b1, 1'b1);

      // Random images, some with a corrupted checksum
      for (int r = 0; r < 8; r++) begin
         int unsigned n;
         logic [7:0]  c;
         bit          bad;
         n = $urandom_range(1, 6);
         set_rand_words(n);
         bad = ($urandom_range(0, 3) == 0);
         c = 8'h00;
         foreach (words[i]) c = c ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
         c = c ^ (8'h01 << $urandom_range(0, 7));
         run_load(16'(n), bad, c, r[0], 1'b1);
      end

      // Largest accepted image fills the address space exactly
      set_rand_words(DEPTH);
      run_load(16'(DEPTH), 1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset after five payload bytes of a 3-word load
      set_rand_words(3);
      exp_q.push_back('{addr: ADDR_W'(BASE_ADDR), data: words[0]});
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] w;
         w = words[i / 4];
         send_byte(w[8*(3 - (i % 4)) +: 8], 1'b0, 1'b0);
      end
      #2 rst = 1'b0;
      #1;
      check_reset_values("midload_reset");
      check("midload_writes_drained", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      set_spec_words();
      run_load(16'd2, 1'b0, 8'h00, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
